// File: rtl/data_unloader.sv
// data_unloader: bridge read port to memory read-request port.
// A rising edge on bridge_rd with a matching upper address nibble issues one
// memory read; the reply (optionally byte-swapped) lands in bridge_rd_data.
// A watchdog replaces a missing reply with 32'hDEADBEEF and sets error.
// Optional feature: define DATA_UNLOADER_PREFETCH_EN to add a one-word
// sequential prefetch buffer that serves the next address without a memory read.
module data_unloader #(
  parameter int unsigned ADDRESS_MASK_UPPER_4 = 0,
  parameter int unsigned ADDRESS_SIZE         = 28,
  parameter int unsigned READ_TIMEOUT         = 255
) (
  input  logic                    clk_74a,
  input  logic                    reset,
  input  logic                    bridge_rd,
  input  logic                    bridge_endian_little,
  input  logic [31:0]             bridge_addr,
  output logic [31:0]             bridge_rd_data,
  output logic                    read_req,
  output logic [ADDRESS_SIZE-1:0] read_addr,
  input  logic                    read_ack,
  input  logic                    read_data_valid,
  input  logic [31:0]             read_data,
  output logic                    busy,
  output logic                    error
);

  localparam logic [3:0]  MaskUpper  = 4'(ADDRESS_MASK_UPPER_4);
  localparam logic [15:0] TimeoutMax = 16'(READ_TIMEOUT);

`ifdef DATA_UNLOADER_PREFETCH_EN
  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StPfReq, StPfWait} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;
`endif

  function automatic logic [31:0] fmt(input logic [31:0] d, input logic swap);
    return swap ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
  endfunction

  state_e                  state_q, state_d;
  logic                    rd_q;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic                    endian_q, endian_d;
  logic [31:0]             data_q, data_d;
  logic                    err_q, err_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [15:0]             cnt_inc;
  logic                    claimed;

`ifdef DATA_UNLOADER_PREFETCH_EN
  logic                    pf_valid_q, pf_valid_d;
  logic [ADDRESS_SIZE-1:0] pf_tag_q, pf_tag_d;
  logic [31:0]             pf_data_q, pf_data_d;
  // Set when a demand read completed with real data, so DONE chains a prefetch.
  logic                    pf_arm_q, pf_arm_d;
  logic                    pf_hit;
`endif

  assign claimed = bridge_rd & ~rd_q & (bridge_addr[31:28] == MaskUpper);
  assign cnt_inc = cnt_q + 16'd1;

`ifdef DATA_UNLOADER_PREFETCH_EN
  assign pf_hit = pf_valid_q & (pf_tag_q == bridge_addr[ADDRESS_SIZE-1:0]);
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    endian_d = endian_q;
    data_d   = data_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
`ifdef DATA_UNLOADER_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_tag_d   = pf_tag_q;
    pf_data_d  = pf_data_q;
    pf_arm_d   = pf_arm_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (claimed) begin
`ifdef DATA_UNLOADER_PREFETCH_EN
          if (pf_hit) begin
            // Served from the buffer; DONE then fetches the following word.
            data_d   = fmt(pf_data_q, bridge_endian_little);
            addr_d   = bridge_addr[ADDRESS_SIZE-1:0];
            endian_d = bridge_endian_little;
            pf_arm_d = 1'b1;
            state_d  = StDone;
          end else begin
            pf_valid_d = 1'b0;
            pf_arm_d   = 1'b0;
            addr_d     = bridge_addr[ADDRESS_SIZE-1:0];
            endian_d   = bridge_endian_little;
            cnt_d      = 16'd0;
            state_d    = StReq;
          end
`else
          addr_d   = bridge_addr[ADDRESS_SIZE-1:0];
          endian_d = bridge_endian_little;
          cnt_d    = 16'd0;
          state_d  = StReq;
`endif
        end
      end

      StReq: begin
        cnt_d = cnt_inc;
        if (read_ack && read_data_valid) begin
          data_d  = fmt(read_data, endian_q);
          state_d = StDone;
`ifdef DATA_UNLOADER_PREFETCH_EN
          pf_arm_d = 1'b1;
`endif
        end else if (read_ack) begin
          cnt_d   = 16'd0;
          state_d = StWait;
        end else if (cnt_inc == TimeoutMax) begin
          data_d  = 32'hDEADBEEF;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end

      StWait: begin
        if (read_data_valid) begin
          data_d  = fmt(read_data, endian_q);
          state_d = StDone;
`ifdef DATA_UNLOADER_PREFETCH_EN
          pf_arm_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutMax) begin
            data_d  = 32'hDEADBEEF;
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
`ifdef DATA_UNLOADER_PREFETCH_EN
        if (pf_arm_q) begin
          addr_d     = addr_q + ADDRESS_SIZE'(4);
          pf_valid_d = 1'b0;
          pf_arm_d   = 1'b0;
          cnt_d      = 16'd0;
          state_d    = StPfReq;
        end
`endif
      end

`ifdef DATA_UNLOADER_PREFETCH_EN
      // Prefetch timeouts leave the tag invalid and never raise error.
      StPfReq: begin
        cnt_d = cnt_inc;
        if (read_ack && read_data_valid) begin
          pf_data_d  = read_data;
          pf_tag_d   = addr_q;
          pf_valid_d = 1'b1;
          state_d    = StIdle;
        end else if (read_ack) begin
          cnt_d   = 16'd0;
          state_d = StPfWait;
        end else if (cnt_inc == TimeoutMax) begin
          state_d = StIdle;
        end
      end

      StPfWait: begin
        if (read_data_valid) begin
          pf_data_d  = read_data;
          pf_tag_d   = addr_q;
          pf_valid_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutMax) state_d = StIdle;
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    // A new request while busy is dropped; only the overrun is recorded.
    if (claimed && (state_q != StIdle)) err_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      endian_q <= 1'b0;
      data_q   <= 32'd0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      rd_q     <= bridge_rd;
      addr_q   <= addr_d;
      endian_q <= endian_d;
      data_q   <= data_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef DATA_UNLOADER_PREFETCH_EN
  // Prefetch buffer registers.
  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      pf_valid_q <= 1'b0;
      pf_tag_q   <= '0;
      pf_data_q  <= 32'd0;
      pf_arm_q   <= 1'b0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_tag_q   <= pf_tag_d;
      pf_data_q  <= pf_data_d;
      pf_arm_q   <= pf_arm_d;
    end
  end

  assign read_req = (state_q == StReq) | (state_q == StPfReq);
`else
  assign read_req = (state_q == StReq);
`endif

  assign busy           = (state_q != StIdle);
  assign read_addr      = addr_q;
  assign bridge_rd_data = data_q;
  assign error          = err_q;

endmodule

// File: tb/tb_data_unloader.sv
// Directed bench for data_unloader (mask nibble 1, timeout 8).
// Prefetch scenario is compiled only when DATA_UNLOADER_PREFETCH_EN is defined.
module tb_data_unloader;

  logic        clk_74a = 1'b0;
  logic        reset;
  logic        bridge_rd;
  logic        bridge_endian_little;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_rd_data;
  logic        read_req;
  logic [27:0] read_addr;
  logic        read_ack;
  logic        read_data_valid;
  logic [31:0] read_data;
  logic        busy;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  data_unloader #(
    .ADDRESS_MASK_UPPER_4(1),
    .ADDRESS_SIZE        (28),
    .READ_TIMEOUT        (8)
  ) dut (
    .clk_74a             (clk_74a),
    .reset               (reset),
    .bridge_rd           (bridge_rd),
    .bridge_endian_little(bridge_endian_little),
    .bridge_addr         (bridge_addr),
    .bridge_rd_data      (bridge_rd_data),
    .read_req            (read_req),
    .read_addr           (read_addr),
    .read_ack            (read_ack),
    .read_data_valid     (read_data_valid),
    .read_data           (read_data),
    .busy                (busy),
    .error               (error)
  );

  always #5 clk_74a = ~clk_74a;

  // Drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_74a);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_cmp++; if (bridge_rd_data !== 32'h0) begin n_bad++;
      $display("FAIL reset_data: got %h want %h", bridge_rd_data, 32'h0); end
    n_cmp++; if (read_req !== 1'b0) begin n_bad++;
      $display("FAIL reset_req: got %b want 0", read_req); end
    n_cmp++; if (read_addr !== 28'h0) begin n_bad++;
      $display("FAIL reset_addr: got %h want 0", read_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (error !== 1'b0) begin n_bad++;
      $display("FAIL reset_error: got %b want 0", error); end
  endtask

  // Ack in REQ, data in WAIT; endian flips after claim to prove it was captured.
  task automatic test_read(input logic [31:0] addr, input logic endian,
                           input logic [31:0] mem, input logic [31:0] exp);
    logic [31:0] prev;
    prev = bridge_rd_data;
    bridge_addr = addr; bridge_endian_little = endian; bridge_rd = 1'b1; read_ack = 1'b1;
    tick();  // claimed -> REQ
    bridge_rd = 1'b0; bridge_endian_little = ~endian;
    n_cmp++; if (read_req !== 1'b1) begin n_bad++;
      $display("FAIL read_req_asserted: got %b want 1", read_req); end
    n_cmp++; if (read_addr !== addr[27:0]) begin n_bad++;
      $display("FAIL read_addr: got %h want %h", read_addr, addr[27:0]); end
    tick();  // ack -> WAIT
    read_ack = 1'b0; read_data_valid = 1'b1; read_data = mem;
    n_cmp++; if (bridge_rd_data !== prev) begin n_bad++;
      $display("FAIL data_early: got %h want %h", bridge_rd_data, prev); end
    tick();  // data latched, third edge after request
    read_data_valid = 1'b0; read_data = 32'h0;
    n_cmp++; if (bridge_rd_data !== exp) begin n_bad++;
      $display("FAIL read_data: got %h want %h", bridge_rd_data, exp); end
    n_cmp++; if (error !== 1'b0) begin n_bad++;
      $display("FAIL read_error: got %b want 0", error); end
    tick();  // DONE -> IDLE
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL read_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_unclaimed();
    bridge_addr = 32'h2000_0000; bridge_endian_little = 1'b0; bridge_rd = 1'b1;
    tick();
    n_cmp++; if (read_req !== 1'b0) begin n_bad++;
      $display("FAIL unclaimed_req: got %b want 0", read_req); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL unclaimed_busy: got %b want 0", busy); end
    tick();
    bridge_rd = 1'b0;
    n_cmp++; if (bridge_rd_data !== 32'h4433_2211) begin n_bad++;
      $display("FAIL unclaimed_data: got %h want %h", bridge_rd_data, 32'h4433_2211); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bridge_addr = 32'h1000_0020; bridge_rd = 1'b1; read_ack = 1'b1;
    tick();  // REQ
    bridge_rd = 1'b0;
    tick();  // WAIT, counter cleared
    read_ack = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    // 8 counting cycles in WAIT, then one in DONE.
    n_cmp++; if (n !== 9) begin n_bad++;
      $display("FAIL timeout_cycles: got %0d want 9", n); end
    n_cmp++; if (bridge_rd_data !== 32'hDEADBEEF) begin n_bad++;
      $display("FAIL timeout_data: got %h want deadbeef", bridge_rd_data); end
    n_cmp++; if (error !== 1'b1) begin n_bad++;
      $display("FAIL timeout_error: got %b want 1", error); end
    n_cmp++; if (read_req !== 1'b0) begin n_bad++;
      $display("FAIL timeout_req: got %b want 0", read_req); end
  endtask

  task automatic test_reset_mid();
    bridge_addr = 32'h1000_0050; bridge_rd = 1'b1; read_ack = 1'b1;
    tick();
    bridge_rd = 1'b0;
    tick();  // WAIT
    read_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({bridge_rd_data, read_req, read_addr, busy, error} !== 63'h0) begin n_bad++;
      $display("FAIL midreset_outputs: data %h req %b addr %h busy %b err %b want all 0",
               bridge_rd_data, read_req, read_addr, busy, error); end
    tick();
    reset = 1'b0;
    tick();
    read_data_valid = 1'b1; read_data = 32'h1234_5678;
    tick();
    read_data_valid = 1'b0;
    n_cmp++; if (bridge_rd_data !== 32'h0) begin n_bad++;
      $display("FAIL late_valid_data: got %h want 0", bridge_rd_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL late_valid_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    bridge_addr = 32'h1000_0030; bridge_endian_little = 1'b0; bridge_rd = 1'b1; read_ack = 1'b1;
    tick();  // REQ
    bridge_rd = 1'b0;
    tick();  // WAIT
    read_ack = 1'b0;
    bridge_addr = 32'h1000_0040; bridge_rd = 1'b1;
    tick();  // overrun seen, still WAIT
    bridge_rd = 1'b0;
    n_cmp++; if (error !== 1'b1) begin n_bad++;
      $display("FAIL overrun_error: got %b want 1", error); end
    n_cmp++; if (read_addr !== 28'h000_0030) begin n_bad++;
      $display("FAIL overrun_addr: got %h want 0000030", read_addr); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL overrun_busy: got %b want 1", busy); end
    read_data_valid = 1'b1; read_data = 32'hA5A5_5A5A;
    tick();
    read_data_valid = 1'b0;
    n_cmp++; if (bridge_rd_data !== 32'hA5A5_5A5A) begin n_bad++;
      $display("FAIL overrun_data: got %h want a5a55a5a", bridge_rd_data); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL overrun_idle: got %b want 0", busy); end
  endtask

`ifdef DATA_UNLOADER_PREFETCH_EN
  task automatic test_prefetch();
    bridge_addr = 32'h1000_0000; bridge_endian_little = 1'b0; bridge_rd = 1'b1; read_ack = 1'b1;
    tick();  // REQ
    bridge_rd = 1'b0;
    tick();  // WAIT
    read_ack = 1'b0; read_data_valid = 1'b1; read_data = 32'h0102_0304;
    tick();  // DONE
    read_data_valid = 1'b0;
    n_cmp++; if (bridge_rd_data !== 32'h0102_0304) begin n_bad++;
      $display("FAIL pf_demand_data: got %h want 01020304", bridge_rd_data); end
    tick();  // speculative read of +4
    n_cmp++; if (read_req !== 1'b1 || read_addr !== 28'h000_0004) begin n_bad++;
      $display("FAIL pf_issue: req %b addr %h want 1 0000004", read_req, read_addr); end
    read_ack = 1'b1; read_data_valid = 1'b1; read_data = 32'hCAFE_F00D;
    tick();  // prefetch lands
    read_ack = 1'b0; read_data_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL pf_landed_idle: got %b want 0", busy); end
    bridge_addr = 32'h1000_0004; bridge_rd = 1'b1;
    tick();  // hit
    bridge_rd = 1'b0;
    n_cmp++; if (bridge_rd_data !== 32'hCAFE_F00D) begin n_bad++;
      $display("FAIL pf_hit_data: got %h want cafef00d", bridge_rd_data); end
    n_cmp++; if (read_req !== 1'b0) begin n_bad++;
      $display("FAIL pf_hit_noreq: got %b want 0", read_req); end
    apply_reset();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; bridge_rd = 1'b0; bridge_endian_little = 1'b0; bridge_addr = 32'h0;
    read_ack = 1'b0; read_data_valid = 1'b0; read_data = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_read(32'h1000_0010, 1'b0, 32'h1122_3344, 32'h1122_3344);
    test_read(32'h1000_0010, 1'b1, 32'h1122_3344, 32'h4433_2211);
    test_unclaimed();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef DATA_UNLOADER_PREFETCH_EN
    apply_reset();
    test_prefetch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_unloader.md
DATA_UNLOADER -- requirements
Module: data_unloader

Interface
REQ-001 SHALL have parameter ADDRESS_MASK_UPPER_4, default 0: a bridge read is claimed only when bridge_addr[31:28] equals this value.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 28: width of read_addr.
REQ-003 SHALL have parameter READ_TIMEOUT, default 255: maximum number of cycles to wait for memory data, range 1..65535.
REQ-004 SHALL have port clk_74a, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port bridge_rd, input, 1 bit: read strobe; its rising edge starts a request.
REQ-007 SHALL have port bridge_endian_little, input, 1 bit: when 1, bridge_rd_data is byte-swapped.
REQ-008 SHALL have port bridge_addr, input, 32 bits: byte address of the read.
REQ-009 SHALL have port bridge_rd_data, output, 32 bits: registered read response.
REQ-010 SHALL have port read_req, output, 1 bit: memory read request, held until acknowledged.
REQ-011 SHALL have port read_addr, output, ADDRESS_SIZE bits: memory read address.
REQ-012 SHALL have port read_ack, input, 1 bit: memory has accepted read_req.
REQ-013 SHALL have port read_data_valid, input, 1 bit: read_data is valid this cycle.
REQ-014 SHALL have port read_data, input, 32 bits: memory read data.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port error, output, 1 bit: sticky flag, set by a timeout or an overrun.

Function
REQ-017 SHALL register bridge_rd every cycle; a claimed request is one where bridge_rd is 1, the registered bridge_rd is 0, and bridge_addr[31:28] equals ADDRESS_MASK_UPPER_4.
REQ-018 SHALL implement states IDLE, REQ, WAIT and DONE.
REQ-019 IDLE + claimed request: SHALL capture read_addr from bridge_addr[ADDRESS_SIZE-1:0], capture the endian bit, and go to REQ.
REQ-020 In REQ, read_req SHALL be 1; on read_ack it SHALL go to WAIT and clear the timeout counter.
REQ-021 In REQ, read_ack and read_data_valid in the same cycle SHALL take the data and go directly to DONE.
REQ-022 In WAIT, read_data_valid SHALL latch read_data into bridge_rd_data the next cycle, byte-swapped when the captured endian bit is 1, and go to DONE.
REQ-023 The timeout counter SHALL increment in REQ and in WAIT.
REQ-024 When the counter reaches READ_TIMEOUT: bridge_rd_data SHALL become 32'hDEADBEEF, error SHALL be set, read_req SHALL drop, and the state SHALL go to DONE.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-026 Latency from a claimed request to bridge_rd_data update SHALL be 3 cycles when read_ack arrives in the REQ cycle and read_data_valid arrives on the next cycle.
REQ-027 A claimed request while busy SHALL be dropped, SHALL set error, and SHALL leave the in-flight transaction unaffected.
REQ-028 Unclaimed addresses SHALL leave bridge_rd_data and the state unchanged.
REQ-029 read_data_valid in IDLE or DONE SHALL be ignored.
REQ-030 bridge_rd_data SHALL hold its last value until the next update.

Reset
REQ-031 Asserting reset SHALL immediately force: state IDLE, read_req 0, read_addr 0, bridge_rd_data 0, busy 0, error 0, timeout counter 0, registered bridge_rd 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction; a read_data_valid arriving after reset releases SHALL be ignored.

Configuration
REQ-033 SHALL support macro DATA_UNLOADER_PREFETCH_EN.
REQ-034 With DATA_UNLOADER_PREFETCH_EN defined, after DONE the block SHALL issue a speculative read of read_addr+4 into a one-word prefetch buffer tagged with its address.
REQ-035 With the macro defined, a claimed request whose address matches the valid tag SHALL update bridge_rd_data on the next cycle without a memory read.
REQ-036 With the macro defined, a miss SHALL invalidate the tag and proceed per REQ-019; a prefetch timeout SHALL invalidate the tag without setting error.
REQ-037 With the macro undefined, the block SHALL contain no prefetch logic and behave exactly per REQ-017..REQ-030.

Verification
REQ-038 Scenario: read at 0x1000_0010, ADDRESS_MASK_UPPER_4=1, ack immediate, data 0x11223344 one cycle later, endian 0 -> bridge_rd_data 0x11223344 three cycles after the request, error 0.
REQ-039 Scenario: same read with bridge_endian_little=1 -> bridge_rd_data 0x44332211.
REQ-040 Scenario: read at 0x2000_0000 with mask 1 -> no read_req, bridge_rd_data unchanged.
REQ-041 Scenario: READ_TIMEOUT=8, never send read_data_valid -> after 8 cycles, bridge_rd_data 0xDEADBEEF, error 1, state IDLE.
REQ-042 Scenario: second claimed request while in WAIT -> first transaction completes normally and error becomes 1.
REQ-043 Scenario: PREFETCH_EN defined, reads at 0x1000_0000 then 0x1000_0004 after the prefetch lands -> second read_data returned on the next cycle with no new read_req; reset pulse in WAIT -> all outputs 0.
